// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter sharing one 32-bit adder with 1-cycle result registers.
// Optional op counter enabled by defining ADDER_SHARE_ARB_STATS_EN.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        c32
);
  assign {c32, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module adder_share_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_cin,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_sum,
  output logic             resp0_c32,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_cin,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_sum,
  output logic             resp1_c32,
  output logic [CNT_W-1:0] op_count
);

  logic        prio;
  logic        elig0, elig1;
  logic        grant0, grant1;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [31:0] add_s;
  logic        add_c32;

  // A slot may be refilled in the same cycle its result is drained
  assign elig0 = req0_valid & (~resp0_valid | resp0_ready);
  assign elig1 = req1_valid & (~resp1_valid | resp1_ready);

  assign grant0 = ~rst & elig0 & (~elig1 | ~prio);
  assign grant1 = ~rst & elig1 & (~elig0 | prio);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign add_a   = grant1 ? req1_a   : req0_a;
  assign add_b   = grant1 ? req1_b   : req0_b;
  assign add_cin = grant1 ? req1_cin : req0_cin;

  adder32 u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .s   (add_s),
    .c32 (add_c32)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp0_sum   <= '0;
      resp0_c32   <= 1'b0;
    end else if (grant0) begin
      resp0_valid <= 1'b1;
      resp0_sum   <= add_s;
      resp0_c32   <= add_c32;
    end else if (resp0_ready) begin
      resp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp1_valid <= 1'b0;
      resp1_sum   <= '0;
      resp1_c32   <= 1'b0;
    end else if (grant1) begin
      resp1_valid <= 1'b1;
      resp1_sum   <= add_s;
      resp1_c32   <= add_c32;
    end else if (resp1_ready) begin
      resp1_valid <= 1'b0;
    end
  end

`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant0 | grant1) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign op_count = cnt;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb.
// Instantiates CNT_W=4 so the counter wrap is reachable.
module tb_adder_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        resp0_valid, resp0_ready, resp0_c32;
  logic [31:0] resp0_sum;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic        resp1_valid, resp1_ready, resp1_c32;
  logic [31:0] resp1_sum;
  logic [3:0]  op_count;

  int checks = 0;
  int errors = 0;

`ifdef ADDER_SHARE_ARB_STATS_EN
  localparam logic [3:0] WRAP_EXP = 4'd1;
`else
  localparam logic [3:0] WRAP_EXP = 4'd0;
`endif

  adder_share_arb #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_cin    (req0_cin),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_sum   (resp0_sum),
    .resp0_c32   (resp0_c32),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_cin    (req1_cin),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_sum   (resp1_sum),
    .resp1_c32   (resp1_c32),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
    req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
  endtask

  task automatic set1(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
    req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // reset: readies forced low, registers cleared
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    step();
    chk("rst_valid0", resp0_valid, 0);
    chk("rst_valid1", resp1_valid, 0);
    chk("rst_sum0", resp0_sum, 0);
    chk("rst_c32_1", resp1_c32, 0);
    chk("rst_count", op_count, 0);

    // single op: 1+2+1
    rst = 1'b0;
    set0(1'b1, 32'h1, 32'h2, 1'b1);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    step();
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    chk("single_valid0", resp0_valid, 1);
    chk("single_sum0", resp0_sum, 32'h4);
    chk("single_c32_0", resp0_c32, 0);

    // carry out on requester 1
    set1(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    #1;
    chk("carry_ready1", req1_ready, 1);
    step();
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    chk("carry_valid1", resp1_valid, 1);
    chk("carry_sum1", resp1_sum, 32'h0);
    chk("carry_c32_1", resp1_c32, 1);
    chk("carry_hold0", resp0_valid, 1);

    // drain both
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    step();
    chk("drain_valid0", resp0_valid, 0);
    chk("drain_valid1", resp1_valid, 0);
    chk("drain_keep_sum0", resp0_sum, 32'h4);

    // contention: 6 cycles, grants 0,1,0,1,0,1
    set0(1'b1, 32'h10, 32'h20, 1'b0);
    set1(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_ready0", req0_ready, (i % 2 == 0));
      chk("cont_ready1", req1_ready, (i % 2 == 1));
      step();
      chk("cont_valid0", resp0_valid, (i % 2 == 0));
      chk("cont_valid1", resp1_valid, (i % 2 == 1));
      if (i % 2 == 0) chk("cont_sum0", resp0_sum, 32'h30);
      else begin
        chk("cont_sum1", resp1_sum, 32'h1);
        chk("cont_c32_1", resp1_c32, 1);
      end
    end

    // back-pressure: fill slot 0 with 100+23
    set0(1'b1, 32'd100, 32'd23, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("bp_fill_ready0", req0_ready, 1);
    step();
    chk("bp_fill_sum0", resp0_sum, 32'd123);
    resp0_ready = 1'b0;
    set0(1'b1, 32'd5, 32'd5, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      set1(1'b1, j, 32'd1, 1'b0);
      #1;
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 1);
      step();
      chk("bp_valid0", resp0_valid, 1);
      chk("bp_hold_sum0", resp0_sum, 32'd123);
      chk("bp_sum1", resp1_sum, j + 1);
    end
    // release: drain and refill slot 0 in one cycle
    resp0_ready = 1'b1;
    #1;
    chk("rel_ready0", req0_ready, 1);
    chk("rel_ready1", req1_ready, 0);
    step();
    chk("rel_valid0", resp0_valid, 1);
    chk("rel_sum0", resp0_sum, 32'd10);
    chk("rel_valid1", resp1_valid, 0);

    // reset mid-stream with resp1 held and prio pointing at 1
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b1, 32'd7, 32'd7, 1'b0);
    resp1_ready = 1'b0;
    step();
    chk("mid_sum1", resp1_sum, 32'd14);
    set0(1'b1, 32'd1, 32'd1, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("mid_ready0", req0_ready, 1);
    step();
    chk("mid_valid1", resp1_valid, 1);
    rst = 1'b1;
    set1(1'b1, 32'd3, 32'd3, 1'b0);
    #1;
    chk("mid_rst_ready0", req0_ready, 0);
    chk("mid_rst_ready1", req1_ready, 0);
    step();
    chk("mid_rst_valid0", resp0_valid, 0);
    chk("mid_rst_valid1", resp1_valid, 0);
    chk("mid_rst_sum1", resp1_sum, 0);
    chk("mid_rst_count", op_count, 0);
    rst = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);

    // counter: this grant plus 16 more on requester 0 = 17 grants
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 17; k++) step();
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    chk("count_wrap", op_count, WRAP_EXP);
    step();
    chk("count_idle", op_count, WRAP_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
